// File: rtl/intc_pkg.sv
// Shared constants for the XCR interrupt controller: register offsets,
// controller states and the vector-address format.
package intc_pkg;

  localparam int NSRC = 8;

  localparam logic [2:0] OFS_PEND = 3'd0;
  localparam logic [2:0] OFS_MASK = 3'd1;
  localparam logic [2:0] OFS_EDGE = 3'd2;
  localparam logic [2:0] OFS_VB0  = 3'd3;
  localparam logic [2:0] OFS_VB1  = 3'd4;
  localparam logic [2:0] OFS_VB2  = 3'd5;
  localparam logic [2:0] OFS_ISID = 3'd6;
  localparam logic [2:0] OFS_SWI  = 3'd7;

  localparam int         IVEC_W   = 24;
  localparam logic [1:0] IVEC_LSB = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_e;

  // Vectors are 4-byte slots: {VB2, VB1, VB0[7:5], idx, 2'b00}
  function automatic logic [IVEC_W-1:0] make_ivec(input logic [IVEC_W-1:0] vb,
                                                  input logic [2:0]        idx);
    return {vb[23:8], vb[7:5], idx, IVEC_LSB};
  endfunction

endpackage

// File: rtl/intc_sync.sv
// Per-source two-flop synchronizer plus a third flop for rising-edge detect.
module intc_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s3_q;

endmodule

// File: rtl/xcr_intc.sv
// Eight-source prioritised interrupt controller on the XCR register bus,
// with a request/in-service handshake against the core's IN_ISP flag.
module xcr_intc
  import intc_pkg::*;
#(
  parameter logic [7:0] XBASE = 8'h10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  irq_i,
  input  logic [7:0]  XCRa,
  input  logic [7:0]  XCRo,
  input  logic        XCRwe,
  input  logic        XCRcs,
  output logic [7:0]  XCRi,
  output logic        INT,
  output logic [23:0] IVEC_addr,
  input  logic        IN_ISP
);

  logic [NSRC-1:0] s2_vec, rise_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_sync
      intc_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .async_i(irq_i[gi]),
        .level_o(s2_vec[gi]),
        .rise_o (rise_vec[gi])
      );
    end
  endgenerate

  logic [7:0]  mask_q, edge_q, pend_edge_q, pend_edge_d;
  logic [7:0]  vb0_q, vb1_q, vb2_q;
  logic        isid_active_q, isid_active_d;
  logic [2:0]  isid_idx_q, isid_idx_d;
  logic [2:0]  req_idx_q, req_idx_d;
  state_e      state_q, state_d;
  logic        int_q, int_d;
  logic [23:0] ivec_q, ivec_d;
  logic        isp_q;

  // Address decode: wrap-around subtraction keeps the window check to one compare
  logic [7:0] offset;
  logic       in_range, wr_en, rd_en;
  logic [2:0] ofs;

  assign offset   = XCRa - XBASE;
  assign in_range = (offset[7:3] == 5'd0);
  assign ofs      = offset[2:0];
  assign wr_en    = XCRcs & XCRwe & in_range;
  assign rd_en    = XCRcs & ~XCRwe & in_range;

  logic isp_rise, isp_fall;
  assign isp_rise = IN_ISP & ~isp_q;
  assign isp_fall = ~IN_ISP & isp_q;

  // Level-mode bits track the synchronized input directly; edge bits are latched
  logic [7:0] pend_vec;
  assign pend_vec = (edge_q & pend_edge_q) | (~edge_q & s2_vec);

  logic       cand_valid;
  logic [2:0] cand_idx;

  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pend_vec[i] & mask_q[i]) begin
        cand_valid = 1'b1;
        cand_idx   = 3'(i);
      end
    end
  end

  logic ack;

  always_comb begin
    state_d       = state_q;
    int_d         = int_q;
    ivec_d        = ivec_q;
    req_idx_d     = req_idx_q;
    isid_active_d = isid_active_q;
    isid_idx_d    = isid_idx_q;
    ack           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cand_valid && !IN_ISP) begin
          state_d   = ST_REQ;
          int_d     = 1'b1;
          ivec_d    = make_ivec({vb2_q, vb1_q, vb0_q}, cand_idx);
          req_idx_d = cand_idx;
        end
      end
      ST_REQ: begin
        if (isp_rise) begin
          state_d       = ST_SERV;
          int_d         = 1'b0;
          ack           = 1'b1;
          isid_active_d = 1'b1;
          isid_idx_d    = req_idx_q;
        end
      end
      ST_SERV: begin
        if (isp_fall) begin
          state_d       = ST_IDLE;
          isid_active_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        int_d   = 1'b0;
      end
    endcase
  end

  // Set beats clear: new edges and SWI are OR-ed in after W1C/ack are applied
  logic [7:0] clr_vec, set_vec;

  always_comb begin
    clr_vec = ack ? (8'b1 << req_idx_q) : 8'h00;
    set_vec = rise_vec;
    if (wr_en && ofs == OFS_PEND) clr_vec = clr_vec | XCRo;
    if (wr_en && ofs == OFS_SWI)  set_vec = set_vec | XCRo;
    pend_edge_d = ((pend_edge_q & ~clr_vec) | set_vec) & edge_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      int_q         <= 1'b0;
      ivec_q        <= 24'h0;
      req_idx_q     <= 3'd0;
      isid_active_q <= 1'b0;
      isid_idx_q    <= 3'd0;
      isp_q         <= 1'b0;
      pend_edge_q   <= 8'h00;
    end else begin
      state_q       <= state_d;
      int_q         <= int_d;
      ivec_q        <= ivec_d;
      req_idx_q     <= req_idx_d;
      isid_active_q <= isid_active_d;
      isid_idx_q    <= isid_idx_d;
      isp_q         <= IN_ISP;
      pend_edge_q   <= pend_edge_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= 8'h00;
      edge_q <= 8'h00;
      vb0_q  <= 8'h00;
      vb1_q  <= 8'h00;
      vb2_q  <= 8'h00;
    end else if (wr_en) begin
      case (ofs)
        OFS_MASK: mask_q <= XCRo;
        OFS_EDGE: edge_q <= XCRo;
        OFS_VB0:  vb0_q  <= XCRo;
        OFS_VB1:  vb1_q  <= XCRo;
        OFS_VB2:  vb2_q  <= XCRo;
        default:  ;
      endcase
    end
  end

  always_comb begin
    XCRi = 8'h00;
    if (rd_en) begin
      case (ofs)
        OFS_PEND: XCRi = pend_vec;
        OFS_MASK: XCRi = mask_q;
        OFS_EDGE: XCRi = edge_q;
        OFS_VB0:  XCRi = vb0_q;
        OFS_VB1:  XCRi = vb1_q;
        OFS_VB2:  XCRi = vb2_q;
        OFS_ISID: XCRi = {isid_active_q, 4'b0000, isid_idx_q};
        default:  XCRi = 8'h00;
      endcase
    end
  end

  assign INT       = int_q;
  assign IVEC_addr = ivec_q;

endmodule

// File: tb/tb_xcr_intc.sv
// Directed self-checking bench for xcr_intc: priority, hold, level/edge,
// software interrupts and reset during service.
module tb_xcr_intc;

  localparam logic [7:0] XBASE = 8'h10;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_i;
  logic [7:0]  XCRa, XCRo, XCRi;
  logic        XCRwe, XCRcs;
  logic        INT;
  logic [23:0] IVEC_addr;
  logic        IN_ISP;

  int checks = 0;
  int errors = 0;

  xcr_intc #(.XBASE(XBASE)) dut (
    .clk(clk), .rst(rst), .irq_i(irq_i),
    .XCRa(XCRa), .XCRo(XCRo), .XCRwe(XCRwe), .XCRcs(XCRcs), .XCRi(XCRi),
    .INT(INT), .IVEC_addr(IVEC_addr), .IN_ISP(IN_ISP)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xw_raw(input logic [7:0] a, input logic [7:0] d);
    XCRa = a; XCRo = d; XCRcs = 1'b1; XCRwe = 1'b1;
    tick();
    XCRcs = 1'b0; XCRwe = 1'b0;
  endtask

  task automatic xw(input logic [2:0] ofs, input logic [7:0] d);
    xw_raw(XBASE + {5'd0, ofs}, d);
  endtask

  task automatic xr(input logic [2:0] ofs, output logic [7:0] d);
    XCRa = XBASE + {5'd0, ofs}; XCRcs = 1'b1; XCRwe = 1'b0;
    #1;
    d = XCRi;
    XCRcs = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1; irq_i = 8'h00; XCRa = 8'h00; XCRo = 8'h00; XCRwe = 1'b0; XCRcs = 1'b0; IN_ISP = 1'b0;
    repeat (3) tick();
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL reset_int got %b exp 0", INT); end
    checks++; if (IVEC_addr !== 24'h0) begin errors++; $display("FAIL reset_ivec got %h exp 000000", IVEC_addr); end
    rst = 1'b0;
    tick();
    for (int r = 0; r < 8; r++) begin
      xr(3'(r), v);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_reg%0d got %h exp 00", r, v); end
    end
    xw_raw(XBASE + 8'd8, 8'hFF);
    xr(3'd1, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL out_of_range_write MASK got %h exp 00", v); end
    XCRa = XBASE + 8'd9; XCRcs = 1'b1; XCRwe = 1'b0; #1;
    checks++; if (XCRi !== 8'h00) begin errors++; $display("FAIL out_of_range_read got %h exp 00", XCRi); end
    XCRcs = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_edge_basic();
    logic [7:0] v;
    xw(3'd1, 8'h0C); xw(3'd2, 8'h0C); xw(3'd3, 8'h00); xw(3'd4, 8'h10); xw(3'd5, 8'h00);
    xr(3'd4, v);
    checks++; if (v !== 8'h10) begin errors++; $display("FAIL vb1_rw got %h exp 10", v); end
    irq_i[3] = 1'b1;
    tick(); tick();
    xr(3'd0, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL pend_k1 got %h exp 00", v); end
    tick();
    xr(3'd0, v);
    checks++; if (v !== 8'h08) begin errors++; $display("FAIL pend_k2 got %h exp 08", v); end
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL int_k2 got %b exp 0", INT); end
    irq_i[3] = 1'b0;
    tick();
    checks++; if (INT !== 1'b1 || IVEC_addr !== 24'h00100C) begin errors++; $display("FAIL int_k3 got %b/%h exp 1/00100c", INT, IVEC_addr); end
    tick();
    checks++; if (INT !== 1'b1) begin errors++; $display("FAIL int_hold got %b exp 1", INT); end
    IN_ISP = 1'b1; tick();
    xr(3'd6, v);
    checks++; if (INT !== 1'b0 || v !== 8'h83) begin errors++; $display("FAIL ack got int %b isid %h exp 0/83", INT, v); end
    xr(3'd0, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL ack_clear got %h exp 00", v); end
    IN_ISP = 1'b0; tick();
    xr(3'd6, v);
    checks++; if (v !== 8'h03) begin errors++; $display("FAIL return_isid got %h exp 03", v); end
    tick();
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL idle_no_int got %b exp 0", INT); end
    $display("test_edge_basic done");
  endtask

  task automatic test_priority();
    logic [7:0] v;
    irq_i[3:2] = 2'b11;
    repeat (4) tick();
    checks++; if (INT !== 1'b1 || IVEC_addr !== 24'h001008) begin errors++; $display("FAIL prio_first got %b/%h exp 1/001008", INT, IVEC_addr); end
    IN_ISP = 1'b1; tick();
    xr(3'd6, v);
    checks++; if (v !== 8'h82) begin errors++; $display("FAIL prio_isid got %h exp 82", v); end
    xr(3'd0, v);
    checks++; if (v !== 8'h08) begin errors++; $display("FAIL prio_pend got %h exp 08", v); end
    IN_ISP = 1'b0; tick();
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL prio_gap got %b exp 0", INT); end
    tick();
    checks++; if (INT !== 1'b1 || IVEC_addr !== 24'h00100C) begin errors++; $display("FAIL prio_second got %b/%h exp 1/00100c", INT, IVEC_addr); end
    IN_ISP = 1'b1; tick();
    IN_ISP = 1'b0; irq_i[3:2] = 2'b00; tick(); tick();
    $display("test_priority done");
  endtask

  task automatic test_hold();
    logic [7:0] v;
    xw(3'd1, 8'h0D); xw(3'd2, 8'h0D);
    irq_i[2] = 1'b1;
    repeat (4) tick();
    checks++; if (INT !== 1'b1 || IVEC_addr !== 24'h001008) begin errors++; $display("FAIL hold_start got %b/%h exp 1/001008", INT, IVEC_addr); end
    irq_i[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) xw(3'd1, 8'h09);
      else tick();
      checks++; if (INT !== 1'b1 || IVEC_addr !== 24'h001008) begin errors++; $display("FAIL hold_c%0d got %b/%h exp 1/001008", c, INT, IVEC_addr); end
    end
    IN_ISP = 1'b1; tick();
    xr(3'd6, v);
    checks++; if (INT !== 1'b0 || v !== 8'h82) begin errors++; $display("FAIL hold_ack got int %b isid %h exp 0/82", INT, v); end
    xr(3'd0, v);
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL hold_pend got %h exp 01", v); end
    IN_ISP = 1'b0; tick(); tick();
    checks++; if (INT !== 1'b1 || IVEC_addr !== 24'h001000) begin errors++; $display("FAIL hold_next got %b/%h exp 1/001000", INT, IVEC_addr); end
    IN_ISP = 1'b1; tick();
    IN_ISP = 1'b0; irq_i[2] = 1'b0; irq_i[0] = 1'b0; tick(); tick();
    $display("test_hold done");
  endtask

  task automatic test_level();
    logic [7:0] v;
    xw(3'd2, 8'h00); xw(3'd1, 8'h20);
    irq_i[5] = 1'b1;
    tick(); tick();
    xr(3'd0, v);
    checks++; if (INT !== 1'b0 || v !== 8'h20) begin errors++; $display("FAIL level_pend got int %b pend %h exp 0/20", INT, v); end
    tick();
    checks++; if (INT !== 1'b1 || IVEC_addr !== 24'h001014) begin errors++; $display("FAIL level_int got %b/%h exp 1/001014", INT, IVEC_addr); end
    IN_ISP = 1'b1; tick();
    xr(3'd6, v);
    checks++; if (v !== 8'h85) begin errors++; $display("FAIL level_isid got %h exp 85", v); end
    xw(3'd0, 8'h20);
    xr(3'd0, v);
    checks++; if (v !== 8'h20) begin errors++; $display("FAIL level_w1c got %h exp 20", v); end
    IN_ISP = 1'b0; tick();
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL level_gap got %b exp 0", INT); end
    tick();
    checks++; if (INT !== 1'b1 || IVEC_addr !== 24'h001014) begin errors++; $display("FAIL level_reint got %b/%h exp 1/001014", INT, IVEC_addr); end
    IN_ISP = 1'b1; irq_i[5] = 1'b0;
    repeat (4) tick();
    IN_ISP = 1'b0; tick(); tick();
    xr(3'd0, v);
    checks++; if (INT !== 1'b0 || v !== 8'h00) begin errors++; $display("FAIL level_drop got int %b pend %h exp 0/00", INT, v); end
    $display("test_level done");
  endtask

  task automatic test_swi();
    logic [7:0] v;
    xw(3'd1, 8'h10); xw(3'd2, 8'h10);
    xw(3'd7, 8'h10);
    xr(3'd0, v);
    checks++; if (v !== 8'h10 || INT !== 1'b0) begin errors++; $display("FAIL swi_pend got pend %h int %b exp 10/0", v, INT); end
    xr(3'd7, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL swi_read got %h exp 00", v); end
    tick();
    checks++; if (INT !== 1'b1 || IVEC_addr !== 24'h001010) begin errors++; $display("FAIL swi_int got %b/%h exp 1/001010", INT, IVEC_addr); end
    IN_ISP = 1'b1; tick();
    IN_ISP = 1'b0; tick(); tick();
    irq_i[4] = 1'b1;
    tick(); tick();
    xw(3'd0, 8'h10);
    xr(3'd0, v);
    checks++; if (v !== 8'h10) begin errors++; $display("FAIL set_beats_clear got %h exp 10", v); end
    tick();
    checks++; if (INT !== 1'b1) begin errors++; $display("FAIL swi_edge_int got %b exp 1", INT); end
    IN_ISP = 1'b1; tick();
    IN_ISP = 1'b0; irq_i[4] = 1'b0; tick(); tick();
    $display("test_swi done");
  endtask

  task automatic test_reset_in_serv();
    logic [7:0] v;
    xw(3'd1, 8'h04); xw(3'd2, 8'h04);
    irq_i[2] = 1'b1;
    repeat (4) tick();
    IN_ISP = 1'b1; tick();
    xr(3'd6, v);
    checks++; if (v !== 8'h82) begin errors++; $display("FAIL serv_isid got %h exp 82", v); end
    rst = 1'b1; irq_i[2] = 1'b0;
    #1;
    checks++; if (INT !== 1'b0 || IVEC_addr !== 24'h0) begin errors++; $display("FAIL async_rst got %b/%h exp 0/000000", INT, IVEC_addr); end
    tick(); tick();
    rst = 1'b0;
    for (int r = 0; r < 8; r++) begin
      xr(3'(r), v);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL serv_rst_reg%0d got %h exp 00", r, v); end
    end
    xw(3'd1, 8'h04);
    irq_i[2] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (INT !== 1'b0) begin errors++; $display("FAIL isp_high_c%0d got %b exp 0", c, INT); end
    end
    IN_ISP = 1'b0; tick();
    checks++; if (INT !== 1'b1 || IVEC_addr !== 24'h000008) begin errors++; $display("FAIL post_rst_int got %b/%h exp 1/000008", INT, IVEC_addr); end
    IN_ISP = 1'b1; tick();
    irq_i[2] = 1'b0; IN_ISP = 1'b0; tick();
    $display("test_reset_in_serv done");
  endtask

  initial begin
    test_reset();
    test_edge_basic();
    test_priority();
    test_hold();
    test_level();
    test_swi();
    test_reset_in_serv();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xcr_intc.md
XCR_INTC -- requirements
Module: xcr_intc

Interface
REQ-001 SHALL have parameter XBASE, default 8'h10: XCR address of register 0; registers occupy XBASE..XBASE+7.
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: irq_i  in  8  asynchronous interrupt sources, index 0 highest priority.
REQ-005 SHALL have ports: XCRa  in  8  XCR register address from the core.
REQ-006 SHALL have ports: XCRo  in  8  XCR write data from the core.
REQ-007 SHALL have ports: XCRwe  in  1  XCR write strobe.
REQ-008 SHALL have ports: XCRcs  in  1  XCR chip select.
REQ-009 SHALL have ports: XCRi  out  8  XCR read data to the core.
REQ-010 SHALL have ports: INT  out  1  interrupt request to the core, registered.
REQ-011 SHALL have ports: IVEC_addr  out  24  vector address, registered.
REQ-012 SHALL have ports: IN_ISP  in  1  core in-service flag; rising edge = acknowledge, falling edge = return.

Function
REQ-013 SHALL pass each irq_i bit through a 2-flop synchronizer (s1, s2) plus a third flop s3 for edge detection.
REQ-014 SHALL implement registers at XBASE+n:
- 0 PEND: read pending; write-1-to-clear edge bits.
- 1 MASK: RW, 1 = enabled.
- 2 EDGE: RW, 1 = rising-edge mode, 0 = level mode.
- 3/4/5 VB0/VB1/VB2: RW vector base, bits 7:0/15:8/23:16.
- 6 ISID: read-only {active, 4'b0, idx[2:0]}.
- 7 SWI: write-1-to-set pending, edge-mode bits only; reads 0.
REQ-015 SHALL perform a register write on the rising edge when XCRcs & XCRwe & address in range; other addresses are ignored.
REQ-016 SHALL drive XCRi combinationally from XCRa when XCRcs & !XCRwe & address in range, else 8'h00.
REQ-017 Edge-mode pending bit SHALL set on edge where s2 & !s3, or on SWI write; it SHALL clear on PEND W1C or on acknowledge of that index.
REQ-018 Set SHALL win over clear when both occur in the same cycle.
REQ-019 Level-mode pending bit SHALL equal s2 (not latched); W1C and acknowledge SHALL have no effect on it.
REQ-020 Candidate = lowest index with PEND & MASK set.
REQ-021 INT SHALL rise on the edge after a candidate exists while IN_ISP=0 and the block is in IDLE.
REQ-022 IVEC_addr SHALL load {VB2, VB1, VB0[7:5], idx, 2'b00} on the same edge as INT rises.
REQ-023 FSM IDLE -> REQ when INT rises.
REQ-024 In REQ, INT and IVEC_addr SHALL hold stable, with no re-prioritisation, until IN_ISP rises, regardless of later higher-priority requests or MASK writes.
REQ-025 REQ -> SERV on IN_ISP rising edge (acknowledge): INT drops on that edge, the idx edge pending bit clears, and ISID becomes {1, idx}.
REQ-026 SERV -> IDLE on IN_ISP falling edge: ISID.active clears.
REQ-027 The next INT SHALL be no earlier than one cycle after the return.
REQ-028 If IN_ISP is already high while in IDLE, INT SHALL NOT assert until IN_ISP falls.
REQ-029 If IN_ISP rises while in IDLE (not caused by this block), no acknowledge action SHALL occur.
REQ-030 The IN_ISP edge detector SHALL use a registered copy of IN_ISP; IN_ISP is synchronous to clk.

Reset
REQ-031 rst SHALL asynchronously clear s1/s2/s3, PEND, MASK, EDGE, VB0-2, ISID, and the IN_ISP copy; FSM = IDLE, INT=0, IVEC_addr=24'h0.
REQ-032 Reset during REQ or SERV SHALL abandon the request; after release, INT stays 0 while IN_ISP remains high.

Structure
REQ-033 Register offsets, FSM state encodings and the vector-format constant SHALL live in a shared package intc_pkg.
REQ-034 The per-source synchronizer and edge detector SHALL be one sub-module intc_sync, instantiated 8 times; FSM, register file and priority encoder stay in xcr_intc.

Verification
REQ-035 MASK=8'h0C, EDGE=8'h0C, VB=24'h001000; pulse irq_i[3] high 3 cycles sampled at edge k -> PEND[3]=1 at k+2, INT=1 and IVEC_addr=24'h00100C at k+3.
REQ-036 irq_i[2] and irq_i[3] rise in the same cycle -> IVEC_addr=24'h001008; after ack/return -> second INT with 24'h00100C.
REQ-037 INT held; IN_ISP delayed 5 cycles; irq_i[0] (enabled) rises meanwhile -> INT and IVEC_addr unchanged until ack, then ISID=8'h82.
REQ-038 Level source 5 held high, MASK=8'h20, EDGE=0 -> INT after each IN_ISP fall while level stays high; W1C 8'h20 to PEND leaves PEND[5]=1.
REQ-039 SWI write 8'h10 with MASK[4]=1, EDGE[4]=1 -> PEND=8'h10, INT next cycle; PEND W1C in same cycle as an irq_i[4] edge -> PEND[4] stays 1.
REQ-040 Assert rst in SERV with IN_ISP held high -> all registers 0, INT=0 until IN_ISP falls and a new candidate appears.
